// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and a
// width helper used to size the bit counter.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the serial subtractor. The master issues
// operands and start; the slave (the subtractor) returns status and result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, bout set when a borrow is
// needed from the next bit.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB first, one bit per clock,
// reusing a single full subtractor cell for every bit position.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);

  localparam int CW = clog2(WIDTH) + 1;

  state_t           state_q, state_d;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic             br_q;
  logic             bout_q, ovf_q;
  logic             busy_q, done_q;
  logic [CW-1:0]    cnt_q;
  logic             d_bit, br_next;

  full_subtractor u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .diff (d_bit),
    .bout (br_next)
  );

  // State register plus registered status flags derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values, regardless of statement order.
      state_q <= state_d;
      busy_q  <= (state_d == SHIFT);
      done_q  <= (state_d == DONE);
    end
  end

  // Next-state logic; a new start is only honoured when no operation is in flight.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
    state_d  = state_q;
    accept   = 1'b0;
    last_bit = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == CW'(WIDTH - 1)) begin
          last_bit = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, per-bit shifting and final borrow/overflow capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every datapath register is reset so a mid-operation reset leaves no stale partial result.
      a_q    <= '0;
      b_q    <= '0;
      diff_q <= '0;
      br_q   <= 1'b0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (accept) begin
      a_q   <= bus.a;
      b_q   <= bus.b;
      br_q  <= bus.bin;
      cnt_q <= '0;
    end else if (state_q == SHIFT) begin
      // Written as shifts so the same expression also covers WIDTH = 1.
      diff_q <= (diff_q >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
      a_q    <= a_q >> 1;
      b_q    <= b_q >> 1;
      br_q   <= br_next;
      cnt_q  <= cnt_q + CW'(1);
      if (last_bit) begin
        bout_q <= br_next;
        // Borrow into the MSB differing from borrow out of it means the signed result overflowed.
        ovf_q  <= br_q ^ br_next;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule
